axi4_mem_responder: RTL and testbench
=====================================

Name: axi4_mem_responder

Overview:
- AXI4 subordinate (responder) that terminates one slave port of the AXI interconnect and services its requests.
- Contains a word-addressed RAM with byte enables.
- Handles full AXI4 bursts (FIXED/INCR/WRAP) with independent read and write engines.
- One outstanding transaction per direction. Replaces the always-ready, single-beat slave models on S0–S3 of the interconnect bench.

Parameters:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width (fixed 32; WSTRB 4 bits).
- MEM_ADDR_BITS, 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB).

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- AWADDR in 32, AWLEN in 8, AWSIZE in 3, AWBURST in 2, AWVALID in 1, AWREADY out 1: write address channel.
- WDATA in 32, WSTRB in 4, WLAST in 1, WVALID in 1, WREADY out 1: write data channel.
- BRESP out 2, BVALID out 1, BREADY in 1: write response channel.
- ARADDR in 32, ARLEN in 8, ARSIZE in 3, ARBURST in 2, ARVALID in 1, ARREADY out 1: read address channel.
- RDATA out 32, RRESP out 2, RLAST out 1, RVALID out 1, RREADY in 1: read data channel.

Behaviour:
- Reset (ARESET=1 at an edge):
  - Both FSMs go to IDLE; beat counters cleared.
  - All outputs 0: AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP, RLAST.
  - RAM contents are not reset.
  - Reset mid-burst abandons the burst; RAM writes already committed remain.
- Ready timing: AWREADY/ARREADY are registered. They read 1 from the first cycle after reset deasserts whenever the corresponding FSM is in IDLE.
- Address mapping: word index = ADDR[MEM_ADDR_BITS+1:2]. ADDR[31:30] is the interconnect region select and is ignored.
- Out-of-range: any set bit in ADDR[29:MEM_ADDR_BITS+2] marks the transaction out-of-range.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On the AW handshake, latch addr/len/size/burst, clear beat count, compute the error flag, go to W_DATA.
  - W_DATA: WREADY=1. On each W handshake:
    - If no error, write the RAM byte lanes where WSTRB[i]=1.
    - Advance the address; increment the beat count.
    - On the beat where count==AWLEN, go to W_RESP.
    - WLAST must equal (count==AWLEN) on every beat; any mismatch sets the error flag. The burst still terminates on beat count, not on WLAST.
  - W_RESP: BVALID=1 starting the cycle after the final W handshake. BRESP=2'b10 (SLVERR) if the error flag is set, else 2'b00. Hold until BREADY, then go to W_IDLE.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On the AR handshake, latch fields and perform the first RAM read.
  - First beat: RVALID=1 with RDATA valid in the cycle after the handshake.
  - R_DATA: RDATA/RRESP/RLAST hold stable while RVALID && !RREADY.
  - On each R handshake, load the next beat's data in the following cycle, so back-to-back beats are possible with RREADY held high.
  - RLAST=1 only on beat ARLEN. After the last handshake go to R_IDLE with RVALID=0.
  - On error: every beat has RRESP=2'b10 and RDATA=0, with the full ARLEN+1 beats still returned.
- Address update per beat:
  - FIXED (00): unchanged.
  - INCR (01): addr += 1<<SIZE.
  - WRAP (10): boundary = (LEN+1)<<SIZE; addr wraps to the aligned boundary base when it reaches base+boundary.
  - Reserved (11): treated as INCR, error flag set.
- Error flag (SLVERR) conditions:
  - out-of-range address;
  - SIZE>2;
  - WRAP with LEN not in {1,3,7,15};
  - WRAP with a start address not aligned to 1<<SIZE;
  - burst type 11.
  - Errored writes do not modify RAM.
- INCR bursts crossing the top of RAM wrap modulo the RAM depth. No error is flagged mid-burst.
- Read and write channels are fully independent. A same-cycle read and write to the same word returns the old data (read-first).

Test Plan:
- Reset: hold ARESET 5 cycles -> all outputs 0. First cycle after release -> AWREADY=1 and ARREADY=1.
- Single-beat path: write 0x0000_0100 data 0xDEADBEEF, WSTRB F, WLAST 1 -> BVALID next cycle, BRESP 00. Read 0x0000_0100 LEN 0 -> RVALID the cycle after the AR handshake, RDATA 0xDEADBEEF, RRESP 00, RLAST 1.
- INCR burst: write 0x200, LEN 3, data 1,2,3,4 -> single BRESP 00. Read back LEN 3 with RREADY low for 3 cycles on beat 2 -> data 1,2,3,4 in order, beat-2 RDATA stable during the stall, RLAST only on beat 4.
- WRAP burst: write 0x308, LEN 3, SIZE 2, data A,B,C,D -> RAM 0x308=A, 0x30C=B, 0x300=C, 0x304=D. Read back LEN 3 INCR from 0x300 -> C,D,A,B.
- Byte strobes: preload 0x400=0xFFFFFFFF, write 0x0000AAAA with WSTRB 0011 -> readback 0xFFFFAAAA.
- Errors:
  - Write with ADDR bit MEM_ADDR_BITS+2 set -> BRESP 10, RAM unchanged.
  - Write LEN 1 with WLAST on beat 0 -> BRESP 10.
  - Read LEN 2 out-of-range -> 3 beats of RDATA 0, RRESP 10, RLAST on beat 3.

Source files
------------

// File: rtl/axi4_mem_responder.sv
// AXI4 subordinate backed by a word-addressed byte-enabled RAM.
// Independent read/write burst engines (FIXED/INCR/WRAP), one outstanding transaction each.
module axi4_mem_responder #(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int MEM_ADDR_BITS = 10
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic [7:0]              AWLEN,
   input  logic [2:0]              AWSIZE,
   input  logic [1:0]              AWBURST,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    WLAST,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic [1:0]              BRESP,
   output logic                    BVALID,
   input  logic                    BREADY,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic [7:0]              ARLEN,
   input  logic [2:0]              ARSIZE,
   input  logic [1:0]              ARBURST,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   output logic                    RLAST,
   output logic                    RVALID,
   input  logic                    RREADY
);

   localparam int unsigned NB = DATA_WIDTH / 8;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   logic [DATA_WIDTH-1:0] mem [0:(1 << MEM_ADDR_BITS)-1];

   function automatic logic calc_err(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
      logic e;
      e = |a[ADDR_WIDTH-3:MEM_ADDR_BITS+2];
      if (size > 3'd2)      e = 1'b1;
      if (burst == 2'b11)   e = 1'b1;
      if (burst == 2'b10) begin
         if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) e = 1'b1;
         if (size == 3'd1 && a[0])          e = 1'b1;
         if (size == 3'd2 && a[1:0] != '0)  e = 1'b1;
      end
      return e;
   endfunction

   // WRAP keeps the bits above the wrap boundary and wraps the offset within it
   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len,
                                                       input logic [2:0] size, input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] incr, bound, base;
      incr  = ADDR_WIDTH'(1) << size;
      bound = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
      base  = a & ~(bound - ADDR_WIDTH'(1));
      if (burst == 2'b00) return a;
      if (burst == 2'b10) return base | ((a + incr) & (bound - ADDR_WIDTH'(1)));
      return a + incr;
   endfunction

   // ---------------- write engine ----------------
   w_state_t              w_state, w_state_n;
   logic [ADDR_WIDTH-1:0] w_addr, w_addr_nx;
   logic [7:0]            w_len, w_cnt;
   logic [2:0]            w_size;
   logic [1:0]            w_burst;
   logic                  w_err, aw_err, aw_hs, w_hs, w_last_beat, wlast_bad;

   always_comb begin
      aw_hs       = AWVALID && AWREADY;
      w_hs        = WVALID && WREADY;
      w_last_beat = (w_cnt == w_len);
      wlast_bad   = (WLAST != w_last_beat);
      aw_err      = calc_err(AWADDR, AWLEN, AWSIZE, AWBURST);
      w_addr_nx   = next_addr(w_addr, w_len, w_size, w_burst);
      w_state_n   = w_state;
      unique case (w_state)
         W_IDLE:  if (aw_hs)               w_state_n = W_DATA;
         W_DATA:  if (w_hs && w_last_beat) w_state_n = W_RESP;
         W_RESP:  if (BVALID && BREADY)    w_state_n = W_IDLE;
         default:                          w_state_n = W_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         w_state <= W_IDLE;
         w_addr  <= '0;
         w_len   <= '0;
         w_size  <= '0;
         w_burst <= '0;
         w_cnt   <= '0;
         w_err   <= 1'b0;
         AWREADY <= 1'b0;
         WREADY  <= 1'b0;
         BVALID  <= 1'b0;
         BRESP   <= '0;
      end else begin
         w_state <= w_state_n;
         AWREADY <= (w_state_n == W_IDLE);
         WREADY  <= (w_state_n == W_DATA);
         BVALID  <= (w_state_n == W_RESP);
         if (aw_hs) begin
            w_addr  <= AWADDR;
            w_len   <= AWLEN;
            w_size  <= AWSIZE;
            w_burst <= AWBURST;
            w_cnt   <= '0;
            w_err   <= aw_err;
         end
         if (w_hs) begin
            w_addr <= w_addr_nx;
            w_cnt  <= w_cnt + 8'd1;
            if (wlast_bad)   w_err <= 1'b1;
            if (w_last_beat) BRESP <= (w_err || wlast_bad) ? 2'b10 : 2'b00;
         end
         if (BVALID && BREADY) BRESP <= '0;
      end
   end

   // Error state is the flag as of the previous beats; a WLAST slip poisons later beats only
   always_ff @(posedge ACLK) begin
      if (!ARESET && w_hs && !w_err)
         for (int unsigned i = 0; i < NB; i++)
            if (WSTRB[i]) mem[w_addr[MEM_ADDR_BITS+1:2]][8*i +: 8] <= WDATA[8*i +: 8];
   end

   // ---------------- read engine ----------------
   r_state_t              r_state, r_state_n;
   logic [ADDR_WIDTH-1:0] r_addr, r_addr_nx;
   logic [7:0]            r_len, r_cnt;
   logic [2:0]            r_size;
   logic [1:0]            r_burst;
   logic                  r_err, ar_err, ar_hs, r_hs, r_last_beat;

   always_comb begin
      ar_hs       = ARVALID && ARREADY;
      r_hs        = RVALID && RREADY;
      r_last_beat = (r_cnt == r_len);
      ar_err      = calc_err(ARADDR, ARLEN, ARSIZE, ARBURST);
      r_addr_nx   = next_addr(r_addr, r_len, r_size, r_burst);
      r_state_n   = r_state;
      unique case (r_state)
         R_IDLE:  if (ar_hs)               r_state_n = R_DATA;
         R_DATA:  if (r_hs && r_last_beat) r_state_n = R_IDLE;
         default:                          r_state_n = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state <= R_IDLE;
         r_addr  <= '0;
         r_len   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         ARREADY <= 1'b0;
         RVALID  <= 1'b0;
         RDATA   <= '0;
         RRESP   <= '0;
         RLAST   <= 1'b0;
      end else begin
         r_state <= r_state_n;
         ARREADY <= (r_state_n == R_IDLE);
         RVALID  <= (r_state_n == R_DATA);
         if (ar_hs) begin
            r_addr  <= ARADDR;
            r_len   <= ARLEN;
            r_size  <= ARSIZE;
            r_burst <= ARBURST;
            r_cnt   <= '0;
            r_err   <= ar_err;
            RDATA   <= ar_err ? '0 : mem[ARADDR[MEM_ADDR_BITS+1:2]];
            RRESP   <= ar_err ? 2'b10 : 2'b00;
            RLAST   <= (ARLEN == 8'd0);
         end else if (r_hs && !r_last_beat) begin
            r_addr <= r_addr_nx;
            r_cnt  <= r_cnt + 8'd1;
            RDATA  <= r_err ? '0 : mem[r_addr_nx[MEM_ADDR_BITS+1:2]];
            RLAST  <= ((r_cnt + 8'd1) == r_len);
         end
      end
   end

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: expected B/R responses queued at issue, popped at handshake.
module tb_axi4_mem_responder;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
   logic [7:0]  AWLEN, ARLEN;
   logic [2:0]  AWSIZE, ARSIZE;
   logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
   logic [3:0]  WSTRB;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

   always #5 ACLK = ~ACLK;

   axi4_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_ADDR_BITS(10)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } rexp_t;

   rexp_t       rq[$];
   logic [1:0]  bq[$];
   logic [31:0] wq[$];
   int          n_total = 0;
   int          n_pass  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic exp_r(input logic [31:0] d, input logic [1:0] resp, input logic last);
      rexp_t e;
      e.data = d;
      e.resp = resp;
      e.last = last;
      rq.push_back(e);
   endtask

   task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [3:0] strb, input bit early_last);
      int w;
      @(negedge ACLK);
      AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
      w = 0;
      while (!AWREADY && w < 20) begin @(negedge ACLK); w++; end
      check("awready", 32'(AWREADY), 32'd1);
      @(negedge ACLK);
      AWVALID = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         WDATA  = wq.pop_front();
         WSTRB  = strb;
         WLAST  = early_last ? (i == 0) : (i == int'(len));
         WVALID = 1'b1;
         w = 0;
         while (!WREADY && w < 20) begin @(negedge ACLK); w++; end
         check("wready", 32'(WREADY), 32'd1);
         @(negedge ACLK);
      end
      WVALID = 1'b0;
      WLAST  = 1'b0;
      check("bvalid_next", 32'(BVALID), 32'd1);
      BREADY = 1'b1;
      check("bresp", 32'(BRESP), 32'(bq.pop_front()));
      @(negedge ACLK);
      BREADY = 1'b0;
      check("bvalid_drop", 32'(BVALID), 32'd0);
   endtask

   task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int stall_beat, input int stall_cycles);
      int    w;
      rexp_t e;
      @(negedge ACLK);
      ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
      w = 0;
      while (!ARREADY && w < 20) begin @(negedge ACLK); w++; end
      check("arready", 32'(ARREADY), 32'd1);
      @(negedge ACLK);
      ARVALID = 1'b0;
      check("rvalid_first", 32'(RVALID), 32'd1);
      for (int i = 0; i <= int'(len); i++) begin
         e = rq.pop_front();
         if (i == stall_beat) begin
            RREADY = 1'b0;
            for (int s = 0; s < stall_cycles; s++) begin
               @(negedge ACLK);
               check("stall_rvalid", 32'(RVALID), 32'd1);
               check("stall_rdata", RDATA, e.data);
               check("stall_rlast", 32'(RLAST), 32'(e.last));
            end
         end
         RREADY = 1'b1;
         check("rvalid", 32'(RVALID), 32'd1);
         check("rdata", RDATA, e.data);
         check("rresp", 32'(RRESP), 32'(e.resp));
         check("rlast", 32'(RLAST), 32'(e.last));
         @(negedge ACLK);
      end
      RREADY = 1'b0;
      check("rvalid_end", 32'(RVALID), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required earlier completion", $time);
      $fatal(1);
   end

   initial begin
      ARESET = 1'b1;
      AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
      ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;

      // reset: all outputs low
      repeat (5) @(negedge ACLK);
      check("rst_awready", 32'(AWREADY), 32'd0);
      check("rst_wready",  32'(WREADY),  32'd0);
      check("rst_bvalid",  32'(BVALID),  32'd0);
      check("rst_bresp",   32'(BRESP),   32'd0);
      check("rst_arready", 32'(ARREADY), 32'd0);
      check("rst_rvalid",  32'(RVALID),  32'd0);
      check("rst_rdata",   RDATA,        32'd0);
      check("rst_rresp",   32'(RRESP),   32'd0);
      check("rst_rlast",   32'(RLAST),   32'd0);
      ARESET = 1'b0;
      @(negedge ACLK);
      check("post_rst_awready", 32'(AWREADY), 32'd1);
      check("post_rst_arready", 32'(ARREADY), 32'd1);

      // single beat
      wq.push_back(32'hDEADBEEF); bq.push_back(2'b00);
      write_burst(32'h100, 8'd0, 3'd2, 2'b01, 4'hF, 1'b0);
      exp_r(32'hDEADBEEF, 2'b00, 1'b1);
      read_burst(32'h100, 8'd0, 3'd2, 2'b01, -1, 0);

      // INCR burst, stall on beat 2
      for (int i = 1; i <= 4; i++) wq.push_back(32'(i));
      bq.push_back(2'b00);
      write_burst(32'h200, 8'd3, 3'd2, 2'b01, 4'hF, 1'b0);
      for (int i = 1; i <= 4; i++) exp_r(32'(i), 2'b00, i == 4);
      read_burst(32'h200, 8'd3, 3'd2, 2'b01, 1, 3);

      // WRAP burst from 0x308 lands A,B at 0x308/0x30C and C,D at 0x300/0x304
      wq.push_back(32'hA); wq.push_back(32'hB); wq.push_back(32'hC); wq.push_back(32'hD);
      bq.push_back(2'b00);
      write_burst(32'h308, 8'd3, 3'd2, 2'b10, 4'hF, 1'b0);
      exp_r(32'hC, 2'b00, 1'b0); exp_r(32'hD, 2'b00, 1'b0);
      exp_r(32'hA, 2'b00, 1'b0); exp_r(32'hB, 2'b00, 1'b1);
      read_burst(32'h300, 8'd3, 3'd2, 2'b01, -1, 0);
      exp_r(32'hA, 2'b00, 1'b0); exp_r(32'hB, 2'b00, 1'b0);
      exp_r(32'hC, 2'b00, 1'b0); exp_r(32'hD, 2'b00, 1'b1);
      read_burst(32'h308, 8'd3, 3'd2, 2'b10, -1, 0);

      // byte strobes
      wq.push_back(32'hFFFFFFFF); bq.push_back(2'b00);
      write_burst(32'h400, 8'd0, 3'd2, 2'b01, 4'hF, 1'b0);
      wq.push_back(32'h0000AAAA); bq.push_back(2'b00);
      write_burst(32'h400, 8'd0, 3'd2, 2'b01, 4'h3, 1'b0);
      exp_r(32'hFFFFAAAA, 2'b00, 1'b1);
      read_burst(32'h400, 8'd0, 3'd2, 2'b01, -1, 0);

      // out-of-range write aliases word 0x100 but must not modify it
      wq.push_back(32'h12345678); bq.push_back(2'b10);
      write_burst(32'h1100, 8'd0, 3'd2, 2'b01, 4'hF, 1'b0);
      exp_r(32'hDEADBEEF, 2'b00, 1'b1);
      read_burst(32'h100, 8'd0, 3'd2, 2'b01, -1, 0);

      // WLAST on beat 0 of a 2-beat burst
      wq.push_back(32'h11); wq.push_back(32'h22); bq.push_back(2'b10);
      write_burst(32'h500, 8'd1, 3'd2, 2'b01, 4'hF, 1'b1);

      // reserved burst type
      wq.push_back(32'h33); bq.push_back(2'b10);
      write_burst(32'h600, 8'd0, 3'd2, 2'b11, 4'hF, 1'b0);

      // out-of-range read: 3 zero beats with SLVERR
      exp_r(32'h0, 2'b10, 1'b0); exp_r(32'h0, 2'b10, 1'b0); exp_r(32'h0, 2'b10, 1'b1);
      read_burst(32'h1000, 8'd2, 3'd2, 2'b01, -1, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
